// File: rtl/k_fftsched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT sharing one butterfly.
// Optional `K_FFTSCHED_STALL_EN adds a stall input that pauses butterfly issue.
module k_fftsched #(
    parameter int LOG2N    = 4,
    parameter int BFLY_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 scaling_cfg,
`ifdef K_FFTSCHED_STALL_EN
    input  logic                       stall,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr0,
    output logic [LOG2N-1:0]           rd_addr1,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr0,
    output logic [LOG2N-1:0]           wr_addr1,
    output logic [1:0]                 scaling,
    output logic [$clog2(LOG2N)-1:0]   stage
);
    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(LOG2N);
    localparam int BW   = LOG2N - 1;
    localparam int CW   = $clog2(BFLY_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t             state_q;
    logic [SW-1:0]      s_q;
    logic [BW-1:0]      b_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         scal_q;
    logic               busy_q, done_q, rd_en_q;
    logic [LOG2N-1:0]   rd0_q, rd1_q;
    logic [LOG2N-2:0]   tw_q;
    logic [BFLY_LAT-1:0] den_q;
    logic [LOG2N-1:0]   da0_q [BFLY_LAT];
    logic [LOG2N-1:0]   da1_q [BFLY_LAT];

    logic [SW-1:0]      iss_s_d;
    logic [BW-1:0]      iss_b_d;
    logic [LOG2N-1:0]   a0_d, a1_d;
    logic [LOG2N-2:0]   tw_d;
    logic               stall_w;

`ifdef K_FFTSCHED_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    function automatic logic [LOG2N-1:0] rd0_f(input logic [SW-1:0] s, input logic [BW-1:0] b);
        int si, bi, pos, grp;
        si  = int'(s);
        bi  = int'(b);
        pos = bi & ((1 << si) - 1);
        grp = bi >> si;
        return LOG2N'((grp << (si + 1)) | pos);
    endfunction

    function automatic logic [LOG2N-2:0] tw_f(input logic [SW-1:0] s, input logic [BW-1:0] b);
        int si, pos;
        si  = int'(s);
        pos = int'(b) & ((1 << si) - 1);
        if (si > LOG2N - 1) return '0;
        return (LOG2N-1)'(pos << (LOG2N - 1 - si));
    endfunction

    // Butterfly to be presented in the next cycle: next b in ISSUE, first of the next stage out of DRAIN.
    always_comb begin
        iss_s_d = '0;
        iss_b_d = '0;
        if (state_q == ISSUE) begin
            iss_s_d = s_q;
            iss_b_d = b_q + BW'(1);
        end else if (state_q == DRAIN) begin
            iss_s_d = s_q + SW'(1);
        end
        a0_d = rd0_f(iss_s_d, iss_b_d);
        a1_d = a0_d + LOG2N'(1 << int'(iss_s_d));
        tw_d = tw_f(iss_s_d, iss_b_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            scal_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            tw_q    <= '0;
            den_q   <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                da0_q[i] <= '0;
                da1_q[i] <= '0;
            end
        end else begin
            // Write side: read strobe and addresses delayed by the butterfly latency.
            den_q[0] <= rd_en_q;
            da0_q[0] <= rd0_q;
            da1_q[0] <= rd1_q;
            for (int i = 1; i < BFLY_LAT; i++) begin
                den_q[i] <= den_q[i-1];
                da0_q[i] <= da0_q[i-1];
                da1_q[i] <= da1_q[i-1];
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        scal_q  <= scaling_cfg;
                        s_q     <= '0;
                        b_q     <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd0_q   <= a0_d;
                        rd1_q   <= a1_d;
                        tw_q    <= tw_d;
                    end
                end
                ISSUE: begin
                    if (stall_w) begin
                        rd_en_q <= 1'b0;
                    end else if (b_q == BW'(HALF - 1)) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                        rd_en_q <= 1'b0;
                    end else begin
                        b_q     <= iss_b_d;
                        rd_en_q <= 1'b1;
                        rd0_q   <= a0_d;
                        rd1_q   <= a1_d;
                        tw_q    <= tw_d;
                    end
                end
                DRAIN: begin
                    // Hold off the next stage until the last write of this one has landed.
                    if (cnt_q == CW'(BFLY_LAT - 1)) begin
                        if (s_q == SW'(LOG2N - 1)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ISSUE;
                            s_q     <= iss_s_d;
                            b_q     <= '0;
                            rd_en_q <= 1'b1;
                            rd0_q   <= a0_d;
                            rd1_q   <= a1_d;
                            tw_q    <= tw_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign rd_addr0 = rd0_q;
    assign rd_addr1 = rd1_q;
    assign tw_addr  = tw_q;
    assign wr_en    = den_q[BFLY_LAT-1];
    assign wr_addr0 = da0_q[BFLY_LAT-1];
    assign wr_addr1 = da1_q[BFLY_LAT-1];
    assign scaling  = scal_q;
    assign stage    = s_q;

endmodule

// File: tb/tb_k_fftsched.sv
// Scoreboard bench for k_fftsched: a BFLY_LAT=1 instance for sequencing and a BFLY_LAT=3 one for stage-boundary timing.
module tb_k_fftsched;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start3;
    logic [1:0] cfg, cfg3;
    logic       stall, stall3;
    logic       busy, done, rd_en, wr_en;
    logic [3:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [2:0] tw_addr;
    logic [1:0] scaling, stage;
    logic       busy3, done3, rd_en3, wr_en3;
    logic [3:0] rd_addr0_3, rd_addr1_3, wr_addr0_3, wr_addr1_3;
    logic [2:0] tw_addr3;
    logic [1:0] scaling3, stage3;

    k_fftsched #(.LOG2N(LOG2N), .BFLY_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scaling_cfg(cfg),
`ifdef K_FFTSCHED_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .scaling(scaling), .stage(stage));

    k_fftsched #(.LOG2N(LOG2N), .BFLY_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .scaling_cfg(cfg3),
`ifdef K_FFTSCHED_STALL_EN
        .stall(stall3),
`endif
        .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr0(rd_addr0_3), .rd_addr1(rd_addr1_3),
        .tw_addr(tw_addr3), .wr_en(wr_en3), .wr_addr0(wr_addr0_3), .wr_addr1(wr_addr1_3),
        .scaling(scaling3), .stage(stage3));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct { int a0; int a1; int tw; } rd_t;
    typedef struct { int a0; int a1; int sc; } wr_t;
    rd_t rdq[$];
    wr_t wrq[$];
    int  latq[$];
    int  lat3q[$];

    // Hand-computed read vectors: index within the run -> addr0/addr1/tw.
    int hidx[5] = '{0, 1, 9, 27, 31};
    int ha0[5]  = '{0, 2, 1, 3, 7};
    int ha1[5]  = '{1, 3, 3, 11, 15};
    int htw[5]  = '{0, 0, 4, 3, 7};

    task automatic push_run(input int sc, input int lat);
        int span, a0;
        for (int s = 0; s < LOG2N; s++) begin
            span = 1 << s;
            for (int grp = 0; grp < HALF / span; grp++) begin
                for (int pos = 0; pos < span; pos++) begin
                    a0 = grp * 2 * span + pos;
                    rdq.push_back('{a0, a0 + span, pos * (HALF / span)});
                    wrq.push_back('{a0, a0 + span, sc});
                end
            end
        end
        latq.push_back(lat);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int first_rd = -1;
    int rd_idx   = 0;

    // Monitor for the BFLY_LAT=1 instance.
    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            if (rdq.size() == 0) begin
                chk("spurious_rd_en", 1, 0);
            end else begin
                r = rdq.pop_front();
                chk("rd_addr0", int'(rd_addr0), r.a0);
                chk("rd_addr1", int'(rd_addr1), r.a1);
                chk("tw_addr", int'(tw_addr), r.tw);
                for (int j = 0; j < 5; j++) begin
                    if (rd_idx == hidx[j]) begin
                        chk("hand_rd_addr0", int'(rd_addr0), ha0[j]);
                        chk("hand_rd_addr1", int'(rd_addr1), ha1[j]);
                        chk("hand_tw_addr", int'(tw_addr), htw[j]);
                    end
                end
            end
            rd_idx++;
        end
        if (wr_en) begin
            if (wrq.size() == 0) begin
                chk("spurious_wr_en", 1, 0);
            end else begin
                w = wrq.pop_front();
                chk("wr_addr0", int'(wr_addr0), w.a0);
                chk("wr_addr1", int'(wr_addr1), w.a1);
                chk("scaling", int'(scaling), w.sc);
            end
        end
        if (done) begin
            chk("busy_at_done", int'(busy), 0);
            if (latq.size() == 0) chk("spurious_done", 1, 0);
            else chk("done_latency", cyc - first_rd, latq.pop_front());
            chk("reads_left_at_done", rdq.size(), 0);
            chk("writes_left_at_done", wrq.size(), 0);
            first_rd = -1;
            rd_idx   = 0;
        end
    end

    int rc3[$];
    int wc3[$];
    int ra3[$];
    int wa3[$];

    // Monitor for the BFLY_LAT=3 instance: records events, checks stage-boundary timing at done.
    always @(negedge clk) begin
        int bad_lat, bad_addr;
        if (rd_en3) begin
            rc3.push_back(cyc);
            ra3.push_back(int'(rd_addr0_3) * 16 + int'(rd_addr1_3));
        end
        if (wr_en3) begin
            wc3.push_back(cyc);
            wa3.push_back(int'(wr_addr0_3) * 16 + int'(wr_addr1_3));
        end
        if (done3) begin
            chk("lat3_rd_count", rc3.size(), 32);
            chk("lat3_wr_count", wc3.size(), 32);
            if (rc3.size() == 32 && wc3.size() == 32 && lat3q.size() > 0) begin
                chk("lat3_stage_gap", rc3[8] - rc3[7] - 1, 3);
                chk("lat3_rd_after_last_wr", rc3[8] - wc3[7], 1);
                chk("lat3_done_latency", cyc - rc3[0], lat3q.pop_front());
                bad_lat  = 0;
                bad_addr = 0;
                for (int i = 0; i < 32; i++) begin
                    if (wc3[i] - rc3[i] != 3) bad_lat++;
                    if (wa3[i] != ra3[i]) bad_addr++;
                end
                chk("lat3_wr_delay_errors", bad_lat, 0);
                chk("lat3_wr_addr_errors", bad_addr, 0);
            end
            rc3.delete();
            wc3.delete();
            ra3.delete();
            wa3.delete();
        end
    end

    task automatic wait_done(input bit use3, input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (use3 ? done3 : done) got = 1'b1;
        end
        chk(use3 ? "done3_seen" : "done_seen", int'(got), 1);
    endtask

    task automatic pulse_start(input logic [1:0] c);
        @(negedge clk);
        cfg   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; cfg = 2'd0; cfg3 = 2'd0;
        stall = 1'b0; stall3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_stage", int'(stage), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stage boundary with BFLY_LAT=3.
        lat3q.push_back(44);
        @(negedge clk);
        cfg3 = 2'd1; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(1'b1, 200);

        // Plain run, scaling 2, with a mid-run start (cfg 3) that must be ignored.
        push_run(2, 36);
        pulse_start(2'd2);
        cfg = 2'd3;
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 200);
        start = 1'b1;                       // lands in the FIN cycle
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("fin_start_ignored_busy", int'(busy), 0);
        chk("stage_holds_last", int'(stage), 3);

        // Asynchronous reset during stage 2.
        push_run(1, 36);
        pulse_start(2'd1);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (stage == 2'd2) hit = 1'b1;
        end
        chk("reached_stage2", int'(hit), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_rd_en", int'(rd_en), 0);
        chk("arst_wr_en", int'(wr_en), 0);
        chk("arst_rd_addr0", int'(rd_addr0), 0);
        chk("arst_rd_addr1", int'(rd_addr1), 0);
        chk("arst_tw_addr", int'(tw_addr), 0);
        chk("arst_wr_addr0", int'(wr_addr0), 0);
        chk("arst_wr_addr1", int'(wr_addr1), 0);
        chk("arst_scaling", int'(scaling), 0);
        chk("arst_stage", int'(stage), 0);
        rdq.delete();
        wrq.delete();
        latq.delete();
        first_rd = -1;
        rd_idx   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle_busy", int'(busy), 0);

        // Fresh run after reset.
        push_run(3, 36);
        pulse_start(2'd3);
        wait_done(1'b0, 200);

`ifdef K_FFTSCHED_STALL_EN
        // Four stall cycles at stage 0, b=5.
        push_run(2, 40);
        pulse_start(2'd2);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (rd_en && rd_addr0 == 4'd10 && stage == 2'd0) hit = 1'b1;
            else @(negedge clk);
        end
        chk("stall_point_found", int'(hit), 1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rd_en", int'(rd_en), 0);
            chk("stall_rd_addr0", int'(rd_addr0), 10);
            chk("stall_rd_addr1", int'(rd_addr1), 11);
        end
        stall = 1'b0;
        wait_done(1'b0, 200);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

endmodule
